// File: rtl/hamming_job_sequencer.sv
// Job sequencer for the Hamming core: CSR/button-started batches of COUNT
// operations with watchdog, abort path, interrupt and LED status.
module hamming_job_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES  = 65536,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock_100m,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        core_ready,
    output logic        core_start,
    output logic [31:0] core_arg,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        core_abort,
    output logic        irq,
    input  logic [2:0]  fpga_button,
    output logic [2:0]  fpga_led
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [31:0] base_reg, base_job, result;
    logic [15:0] count_reg, count_job, index, index_inc;
    logic [WD_W-1:0] wdog;
    logic        done_flag, timeout_flag, aborted_flag;
    logic        abort_pulse;
    logic [31:0] rd_mux;

    logic [1:0]  sync1, sync2, level, btn_fall;
    logic [DB_W-1:0] db_cnt [2];
    logic        unused_button;

    logic ctrl_wr, start_req, abort_req;
    logic ev_start, ev_issue, ev_done, ev_last, ev_expire, ev_abort;

    assign unused_button = fpga_button[2];

    // Buttons idle high, so synchronizer and debounced level reset to 1.
    always_ff @(posedge clock_100m or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= fpga_button[1:0];
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        btn_fall = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            btn_fall[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST) && !sync2[i];
        end
    end

    assign ctrl_wr   = avs_write && (avs_address == 2'd0);
    assign start_req = (ctrl_wr && avs_writedata[0]) || btn_fall[0];
    assign abort_req = (ctrl_wr && avs_writedata[1]) || btn_fall[1];
    assign index_inc = index + 16'd1;

    always_ff @(posedge clock_100m or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Priority inside WAIT: abort, then core_done, then watchdog expiry.
    always_comb begin
        state_next = state;
        ev_start   = 1'b0;
        ev_issue   = 1'b0;
        ev_done    = 1'b0;
        ev_last    = 1'b0;
        ev_expire  = 1'b0;
        ev_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req && !abort_req) begin
                    ev_start = 1'b1;
                    if (count_reg != '0) state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_req) begin
                    ev_abort   = 1'b1;
                    state_next = S_IDLE;
                end else if (core_ready) begin
                    ev_issue   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_req) begin
                    ev_abort   = 1'b1;
                    state_next = S_IDLE;
                end else if (core_done) begin
                    ev_done = 1'b1;
                    if (index_inc == count_job) begin
                        ev_last    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ISSUE;
                    end
                end else if (wdog == WD_LAST) begin
                    ev_expire  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_start = ev_issue;
        core_arg   = ev_issue ? (base_job + {16'd0, index}) : '0;
        core_abort = abort_pulse;
        irq        = done_flag | timeout_flag | aborted_flag;
        fpga_led   = {timeout_flag | aborted_flag, done_flag, state != S_IDLE};
    end

    // Flag sets are ordered after irq_clear so a same-cycle event is kept.
    always_ff @(posedge clock_100m or negedge reset_n) begin
        if (!reset_n) begin
            base_reg     <= '0;
            count_reg    <= '0;
            base_job     <= '0;
            count_job    <= '0;
            result       <= '0;
            index        <= '0;
            wdog         <= '0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            aborted_flag <= 1'b0;
            abort_pulse  <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            if (avs_write && avs_address == 2'd1) base_reg  <= avs_writedata;
            if (avs_write && avs_address == 2'd2) count_reg <= avs_writedata[15:0];
            if (ctrl_wr && avs_writedata[2]) begin
                done_flag    <= 1'b0;
                timeout_flag <= 1'b0;
                aborted_flag <= 1'b0;
            end
            if (ev_start) begin
                base_job     <= base_reg;
                count_job    <= count_reg;
                result       <= '0;
                index        <= '0;
                done_flag    <= (count_reg == '0);
                timeout_flag <= 1'b0;
                aborted_flag <= 1'b0;
            end
            if (ev_issue)
                wdog <= '0;
            else if (state == S_WAIT)
                wdog <= wdog + 1'b1;
            if (ev_done) begin
                result <= result + core_result;
                index  <= index_inc;
                if (ev_last) done_flag <= 1'b1;
            end
            if (ev_expire) begin
                timeout_flag <= 1'b1;
                abort_pulse  <= 1'b1;
            end
            if (ev_abort) begin
                aborted_flag <= 1'b1;
                abort_pulse  <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux = {index, 12'd0, aborted_flag, timeout_flag, done_flag, state != S_IDLE};
            2'd1: rd_mux = base_reg;
            2'd2: rd_mux = {16'd0, count_reg};
            2'd3: rd_mux = result;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock_100m or negedge reset_n) begin
        if (!reset_n)      avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_mux;
    end

endmodule

// File: tb/tb_hamming_job_sequencer.sv
// Directed bench for hamming_job_sequencer with a small behavioural core that
// answers arg+1 five cycles after each start.
module tb_hamming_job_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        core_ready;
    logic        core_start;
    logic [31:0] core_arg;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;
    logic        core_abort;
    logic        irq;
    logic [2:0]  fpga_button;
    logic [2:0]  fpga_led;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        model_en = 1'b0;
    int          model_cnt = 0;
    logic [31:0] model_arg = '0;
    int          n_starts = 0;
    int          n_dones  = 0;
    logic [31:0] args[$];
    int          start_cyc[$];
    int          abort_cyc[$];

    hamming_job_sequencer #(
        .TIMEOUT_CYCLES (16),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock_100m   (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .core_ready   (core_ready),
        .core_start   (core_start),
        .core_arg     (core_arg),
        .core_done    (core_done),
        .core_result  (core_result),
        .core_abort   (core_abort),
        .irq          (irq),
        .fpga_button  (fpga_button),
        .fpga_led     (fpga_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (!reset_n || core_abort) model_cnt = 0;
        if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
                core_done   = 1'b1;
                core_result = model_arg + 32'd1;
                n_dones++;
            end
        end
        if (core_start) begin
            n_starts++;
            args.push_back(core_arg);
            start_cyc.push_back(cyc);
            if (model_en) begin
                model_arg = core_arg;
                model_cnt = 5;
            end
        end
        if (core_abort) abort_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (fpga_led[0] && k < max) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, fpga_led[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int n0;
        int first;

        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        core_ready    = 1'b1;
        fpga_button   = 3'b111;
        tick(3);
        check("reset_ctl", {26'd0, core_start, core_abort, irq, fpga_led}, 32'd0);
        check("reset_arg", core_arg, 32'd0);
        check("reset_rd", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick(2);
        csr_read(2'd0, rd); check("reset_status", rd, 32'd0);

        // Test 1: BASE=0x10, COUNT=3
        model_en = 1'b1;
        csr_write(2'd1, 32'h10);
        csr_write(2'd2, 32'd3);
        args.delete(); start_cyc.delete();
        csr_write(2'd0, 32'h1);
        check("t1_busy", {31'd0, fpga_led[0]}, 32'd1);
        check("t1_first_start", {31'd0, core_start}, 32'd1);
        wait_idle("t1_wait", 100);
        check("t1_nargs", args.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check("t1_arg", (i < args.size()) ? args[i] : 32'hdead_beef, 32'h10 + i);
        check("t1_spacing", (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : 0, 32'd6);
        csr_read(2'd3, rd); check("t1_result", rd, 32'h36);
        csr_read(2'd0, rd); check("t1_status", rd, 32'h0003_0002);
        check("t1_irq", {31'd0, irq}, 32'd1);
        check("t1_led", {29'd0, fpga_led}, 32'b010);

        csr_write(2'd0, 32'h4);
        check("irq_clear", {28'd0, irq, fpga_led}, 32'd0);

        // Test 2: COUNT=0
        n0 = n_starts;
        csr_write(2'd2, 32'd0);
        csr_write(2'd0, 32'h1);
        check("t2_led", {29'd0, fpga_led}, 32'b010);
        tick(3);
        check("t2_no_start", n_starts - n0, 32'd0);
        csr_read(2'd3, rd); check("t2_result", rd, 32'd0);

        // Test 3: watchdog timeout
        model_en = 1'b0;
        csr_write(2'd0, 32'h4);
        csr_write(2'd2, 32'd2);
        start_cyc.delete(); abort_cyc.delete();
        csr_write(2'd0, 32'h1);
        for (int k = 0; k < 40 && !core_abort; k++) tick(1);
        check("t3_abort_seen", {31'd0, core_abort}, 32'd1);
        tick(1);
        check("t3_abort_pulse", {31'd0, core_abort}, 32'd0);
        check("t3_delay", (abort_cyc.size() > 0 && start_cyc.size() > 0) ?
              abort_cyc[0] - start_cyc[0] : 0, 32'd17);
        check("t3_nstarts", start_cyc.size(), 32'd1);
        csr_read(2'd0, rd); check("t3_status", rd, 32'h0000_0004);
        check("t3_led", {29'd0, fpga_led}, 32'b100);
        check("t3_irq", {31'd0, irq}, 32'd1);

        // Test 4: abort in the same cycle as the third core_done
        model_en = 1'b1;
        csr_write(2'd0, 32'h4);
        csr_write(2'd1, 32'h100);
        csr_write(2'd2, 32'd5);
        n0 = n_dones;
        csr_write(2'd0, 32'h1);
        tick(17);
        csr_write(2'd0, 32'h2);
        check("t4_core_abort", {31'd0, core_abort}, 32'd1);
        check("t4_not_busy", {31'd0, fpga_led[0]}, 32'd0);
        check("t4_ndones", n_dones - n0, 32'd3);
        csr_read(2'd3, rd); check("t4_result", rd, 32'h203);
        csr_read(2'd0, rd); check("t4_status", rd, 32'h0002_0008);
        check("t4_led", {29'd0, fpga_led}, 32'b100);

        // Test 5: reset mid-job, then start-while-busy
        csr_write(2'd0, 32'h4);
        core_ready = 1'b0;
        csr_write(2'd2, 32'd4);
        csr_write(2'd1, 32'h55);
        csr_write(2'd0, 32'h1);
        check("t5_busy", {31'd0, fpga_led[0]}, 32'd1);
        csr_read(2'd1, rd);
        n0 = abort_cyc.size();
        tick(1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_ctl", {26'd0, core_start, core_abort, irq, fpga_led}, 32'd0);
        check("t5_rst_rd", avs_readdata, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("t5_no_abort", abort_cyc.size() - n0, 32'd0);
        csr_read(2'd1, rd); check("t5_base", rd, 32'd0);
        csr_read(2'd2, rd); check("t5_count", rd, 32'd0);
        csr_read(2'd3, rd); check("t5_result", rd, 32'd0);
        csr_read(2'd0, rd); check("t5_status", rd, 32'd0);
        csr_write(2'd1, 32'h20);
        csr_write(2'd2, 32'd2);
        args.delete();
        csr_write(2'd0, 32'h1);
        csr_write(2'd1, 32'h40);
        csr_write(2'd0, 32'h1);
        check("t5_still_busy", {31'd0, fpga_led[0]}, 32'd1);
        core_ready = 1'b1;
        tick(1);
        wait_idle("t5_wait", 100);
        check("t5_nargs", args.size(), 32'd2);
        check("t5_arg0", (args.size() > 0) ? args[0] : 32'hdead_beef, 32'h20);
        csr_read(2'd3, rd); check("t5_result2", rd, 32'h43);
        csr_read(2'd1, rd); check("t5_base_new", rd, 32'h40);

        // Test 6: debounced button start with a preceding glitch
        csr_write(2'd0, 32'h4);
        csr_write(2'd1, 32'h7);
        csr_write(2'd2, 32'd1);
        n0 = n_starts;
        fpga_button = 3'b110;
        tick(3);
        fpga_button = 3'b111;
        tick(20);
        check("t6_glitch_starts", n_starts - n0, 32'd0);
        check("t6_glitch_led", {29'd0, fpga_led}, 32'd0);
        fpga_button = 3'b110;
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (fpga_led[0] && first == 0) first = k;
        end
        check("t6_latency", first, 32'd10);
        wait_idle("t6_wait", 50);
        csr_read(2'd3, rd); check("t6_result", rd, 32'h8);
        fpga_button = 3'b111;
        tick(12);

        // Button abort while the job is held in ISSUE
        core_ready = 1'b0;
        csr_write(2'd0, 32'h1);
        fpga_button = 3'b101;
        tick(12);
        csr_read(2'd0, rd); check("t6_btn_abort", rd, 32'h0000_0008);
        fpga_button = 3'b111;
        tick(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "simulation time limit");
    end

endmodule
